// File: rtl/noc_tx_engine_if.sv
// Core-to-engine packet handshake plus four per-port mesh links.
// master: core/mesh side; slave: noc_tx_engine.
interface noc_tx_engine_if #(
  parameter type pkt_t = logic [41:0]
);
  pkt_t       in_pkt;
  logic [3:0] in_dir_mask;
  logic       in_valid;
  logic       in_ready;
  pkt_t [3:0] tx_pkt;
  logic [3:0] tx_valid;
  logic [3:0] tx_ready;

  modport master (
    output in_pkt,
    output in_dir_mask,
    output in_valid,
    input  in_ready,
    input  tx_pkt,
    input  tx_valid,
    output tx_ready
  );

  modport slave (
    input  in_pkt,
    input  in_dir_mask,
    input  in_valid,
    output in_ready,
    output tx_pkt,
    output tx_valid,
    input  tx_ready
  );
endinterface

// File: rtl/noc_tx_engine.sv
// NoC transmit engine: FIFO of core packets fanned out to N/S/E/W.
// Ports: clk, rst_n, bus (slave), flush, fifo_count, drop_cnt, busy.
package noc_pkg;
  localparam int SRC_W = 8;

  typedef enum logic [1:0] {
    MSG_STATUS = 2'd0,
    MSG_CLAUSE = 2'd1,
    MSG_LEARNT = 2'd2,
    MSG_CTRL   = 2'd3
  } msg_type_t;

  typedef struct packed {
    msg_type_t        msg_type;
    logic [SRC_W-1:0] src_id;
    logic [31:0]      payload;
  } noc_packet_t;
endpackage

module noc_tx_engine
  import noc_pkg::*;
#(
  parameter int               DEPTH         = 4,
  parameter logic [SRC_W-1:0] CORE_ID       = '0,
  parameter logic [3:0]       NEIGHBOR_MASK = 4'b1111
) (
  input  logic                   clk,
  input  logic                   rst_n,
  noc_tx_engine_if.slave         bus,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]             drop_cnt,
  output logic                   busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  noc_packet_t   mem_pkt  [DEPTH];
  logic [3:0]    mem_mask [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW:0]   count;
  logic [3:0]    pending;
  logic [3:0]    pend_nxt;
  logic [3:0]    emask;
  logic [3:0]    valid_vec;
  logic          head_valid;
  logic          accept;
  logic          push;
  logic          drop;
  logic          pop;
  noc_packet_t   stamped;
  noc_packet_t   head_pkt;

  assign emask      = bus.in_dir_mask & NEIGHBOR_MASK;
  assign bus.in_ready = (count < FULL) & ~flush;
  assign accept     = bus.in_valid & bus.in_ready;
  assign push       = accept & (emask != 4'd0);
  assign drop       = accept & (emask == 4'd0);
  assign head_valid = (count != '0);
  // Head leaves once no pending port is left waiting.
  assign pop = head_valid &
               ((pending & ~bus.tx_ready) == 4'd0);

  assign fifo_count   = count;
  assign busy         = head_valid;
  assign valid_vec    = {4{head_valid}} & pending;
  assign bus.tx_valid = valid_vec;

  always_comb begin
    stamped        = bus.in_pkt;
    stamped.src_id = CORE_ID;
    head_pkt       = mem_pkt[rptr];
    for (int i = 0; i < 4; i++) begin
      bus.tx_pkt[i] = valid_vec[i] ? head_pkt : '0;
    end
  end

  // New head's mask loads on the popping edge: no bubble.
  always_comb begin
    pend_nxt = pending & ~bus.tx_ready;
    if (pop) begin
      if (count > ONE) begin
        pend_nxt = mem_mask[rptr + 1'b1];
      end else if (push) begin
        pend_nxt = emask;
      end else begin
        pend_nxt = '0;
      end
    end else if (push && !head_valid) begin
      pend_nxt = emask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr    <= '0;
      wptr    <= '0;
      count   <= '0;
      pending <= '0;
    end else if (flush) begin
      rptr    <= '0;
      wptr    <= '0;
      count   <= '0;
      pending <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      pending <= pend_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pkt[wptr]  <= stamped;
      mem_mask[wptr] <= emask;
    end
  end
endmodule

// File: tb/tb_noc_tx_engine.sv
// Bench for noc_tx_engine: directed timing checks plus
// a per-port scoreboard fed by stimulus, drained by a monitor.
module tb_noc_tx_engine;
  import noc_pkg::*;

  localparam logic [7:0] CID0 = 8'd5;
  localparam logic [7:0] CID1 = 8'd9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush0 = 1'b0;
  logic       flush1 = 1'b0;
  logic [2:0] cnt0, cnt1;
  logic [7:0] drop0, drop1;
  logic       busy0, busy1;

  noc_tx_engine_if #(.pkt_t(noc_packet_t)) b0 ();
  noc_tx_engine_if #(.pkt_t(noc_packet_t)) b1 ();

  noc_tx_engine #(
    .DEPTH(4), .CORE_ID(CID0), .NEIGHBOR_MASK(4'b1111)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .flush(flush0),
    .fifo_count(cnt0), .drop_cnt(drop0), .busy(busy0)
  );

  noc_tx_engine #(
    .DEPTH(4), .CORE_ID(CID1), .NEIGHBOR_MASK(4'b0101)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .flush(flush1),
    .fifo_count(cnt1), .drop_cnt(drop1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  noc_packet_t expq [4][$];
  logic [3:0]  hold = '0;
  noc_packet_t hold_pkt [4];

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic noc_packet_t mk(msg_type_t t, logic [31:0] pl);
    noc_packet_t p;
    p.msg_type = t;
    p.src_id   = 8'hEE;
    p.payload  = pl;
    return p;
  endfunction

  function automatic void exp_push(noc_packet_t p, logic [3:0] m);
    noc_packet_t s;
    s = p;
    s.src_id = CID0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) expq[i].push_back(s);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each handshake against the port's queue and
  // check that a waiting port holds valid and data stable.
  always @(negedge clk) begin
    if (!rst_n || flush0) begin
      for (int i = 0; i < 4; i++) expq[i].delete();
      hold = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i]) begin
          chk($sformatf("hold_valid[%0d]", i), b0.tx_valid[i], 1);
          chk($sformatf("hold_pkt[%0d]", i), b0.tx_pkt[i],
              hold_pkt[i]);
        end
        if (b0.tx_valid[i] && b0.tx_ready[i]) begin
          if (expq[i].size() == 0)
            chk($sformatf("extra_tx[%0d]", i), expq[i].size(), 1);
          else
            chk($sformatf("tx_data[%0d]", i), b0.tx_pkt[i],
                expq[i].pop_front());
        end
        hold[i]     = b0.tx_valid[i] & ~b0.tx_ready[i];
        hold_pkt[i] = b0.tx_pkt[i];
      end
    end
  end

  noc_packet_t pa, pb, p;
  logic [3:0]  fm [4];
  logic [3:0]  m;
  int          sent, cyc, dmodel, k;
  logic        acc;

  initial begin
    b0.in_pkt = '0; b0.in_dir_mask = '0;
    b0.in_valid = 0; b0.tx_ready = '0;
    b1.in_pkt = '0; b1.in_dir_mask = '0;
    b1.in_valid = 0; b1.tx_ready = 4'b1111;
    tick(); tick();
    chk("rst_tx_valid", b0.tx_valid, 0);
    chk("rst_tx_pkt", b0.tx_pkt, 0);
    chk("rst_in_ready", b0.in_ready, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_count", cnt0, 0);
    chk("rst_drop", drop0, 0);
    rst_n = 1;
    tick();

    // Unicast
    b0.tx_ready = 4'b1111;
    pa = mk(MSG_STATUS, 32'h1234);
    b0.in_pkt = pa; b0.in_dir_mask = 4'b0010; b0.in_valid = 1;
    exp_push(pa, 4'b0010);
    tick();
    b0.in_valid = 0;
    chk("uni_valid", b0.tx_valid, 4'b0010);
    chk("uni_src", b0.tx_pkt[1].src_id, CID0);
    chk("uni_payload", b0.tx_pkt[1].payload, 32'h1234);
    chk("uni_other_zero", b0.tx_pkt[0], 0);
    chk("uni_count", cnt0, 1);
    tick();
    chk("uni_empty", cnt0, 0);
    chk("uni_valid_off", b0.tx_valid, 0);

    // Broadcast, staggered ready W,E,S,N
    b0.tx_ready = 4'b0000;
    pa = mk(MSG_CLAUSE, 32'hAAAA_0001);
    pb = mk(MSG_LEARNT, 32'hBBBB_0002);
    b0.in_pkt = pa; b0.in_dir_mask = 4'b1111; b0.in_valid = 1;
    exp_push(pa, 4'b1111);
    tick();
    b0.in_pkt = pb;
    exp_push(pb, 4'b1111);
    tick();
    b0.in_valid = 0;
    chk("bc_valid0", b0.tx_valid, 4'b1111);
    chk("bc_count", cnt0, 2);
    b0.tx_ready = 4'b0001; tick();
    chk("bc_after_w", b0.tx_valid, 4'b1110);
    b0.tx_ready = 4'b0010; tick();
    chk("bc_after_e", b0.tx_valid, 4'b1100);
    b0.tx_ready = 4'b0100; tick();
    chk("bc_after_s", b0.tx_valid, 4'b1000);
    chk("bc_no_pop", cnt0, 2);
    b0.tx_ready = 4'b1000; tick();
    chk("bc_next_valid", b0.tx_valid, 4'b1111);
    chk("bc_next_pkt", b0.tx_pkt[0].payload, 32'hBBBB_0002);
    chk("bc_popped", cnt0, 1);
    b0.tx_ready = 4'b1111; tick();
    chk("bc_empty", cnt0, 0);

    // Edge core: only W and S neighbours
    b1.in_pkt = mk(MSG_STATUS, 32'h55);
    b1.in_dir_mask = 4'b1010; b1.in_valid = 1;
    tick();
    b1.in_valid = 0;
    chk("edge_valid", b1.tx_valid, 0);
    chk("edge_drop1", drop1, 1);
    chk("edge_count", cnt1, 0);
    b1.in_valid = 1;
    for (int i = 0; i < 300; i++) tick();
    b1.in_valid = 0;
    chk("edge_drop_sat", drop1, 255);
    b1.in_pkt = mk(MSG_CTRL, 32'h77);
    b1.in_dir_mask = 4'b1111; b1.in_valid = 1;
    tick();
    b1.in_valid = 0;
    chk("edge_masked", b1.tx_valid, 4'b0101);
    chk("edge_src", b1.tx_pkt[0].src_id, CID1);
    chk("edge_e_zero", b1.tx_pkt[1], 0);
    tick();
    chk("edge_empty", cnt1, 0);
    chk("edge_drop_hold", drop1, 255);

    // Full / backpressure
    fm[0] = 4'b0011; fm[1] = 4'b1100;
    fm[2] = 4'b1111; fm[3] = 4'b0001;
    b0.tx_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      p = mk(MSG_STATUS, 32'h100 + i);
      b0.in_pkt = p; b0.in_dir_mask = fm[i]; b0.in_valid = 1;
      exp_push(p, fm[i]);
      tick();
    end
    chk("full_ready", b0.in_ready, 0);
    chk("full_count", cnt0, 4);
    p = mk(MSG_CLAUSE, 32'h104);
    b0.in_pkt = p; b0.in_dir_mask = 4'b0110;
    tick();
    chk("full_hold_count", cnt0, 4);
    b0.tx_ready = 4'b1111;
    chk("full_pop_ready", b0.in_ready, 0);
    tick();
    chk("full_after_pop", cnt0, 3);
    chk("full_ready_back", b0.in_ready, 1);
    exp_push(p, 4'b0110);
    tick();
    b0.in_valid = 0;
    chk("full_pushpop", cnt0, 3);
    k = 0;
    while (busy0 && k < 50) begin tick(); k++; end
    chk("full_drain", busy0, 0);

    // Flush mid-broadcast
    b0.tx_ready = 4'b0000;
    p = mk(MSG_STATUS, 32'hF1);
    b0.in_pkt = p; b0.in_dir_mask = 4'b1111; b0.in_valid = 1;
    exp_push(p, 4'b1111);
    tick();
    b0.in_valid = 0;
    b0.tx_ready = 4'b0011; tick();
    chk("fl_two_done", b0.tx_valid, 4'b1100);
    b0.tx_ready = 4'b1100; flush0 = 1; b0.in_valid = 1;
    #1;
    chk("fl_in_ready", b0.in_ready, 0);
    @(posedge clk); #1;
    flush0 = 0; b0.in_valid = 0; b0.tx_ready = 4'b0000;
    chk("fl_valid", b0.tx_valid, 0);
    chk("fl_count", cnt0, 0);
    chk("fl_drop", drop1, 255);
    tick();
    chk("fl_stays", b0.tx_valid, 0);

    // Reset mid-broadcast, between edges
    p = mk(MSG_CLAUSE, 32'hD0);
    b0.in_pkt = p; b0.in_dir_mask = 4'b1111; b0.in_valid = 1;
    exp_push(p, 4'b1111);
    tick();
    b0.in_valid = 0;
    b0.tx_ready = 4'b0101; tick();
    b0.tx_ready = 4'b0000;
    chk("rm_two_done", b0.tx_valid, 4'b1010);
    #2 rst_n = 0;
    #1;
    chk("rm_valid", b0.tx_valid, 0);
    chk("rm_count", cnt0, 0);
    chk("rm_drop1", drop1, 0);
    chk("rm_ready", b0.in_ready, 1);
    tick();
    rst_n = 1;
    tick();

    // Random stress
    sent = 0; cyc = 0; dmodel = 0;
    b0.in_valid = 0;
    while (sent < 1000 && cyc < 20000) begin
      b0.tx_ready = 4'($urandom);
      if (!b0.in_valid && $urandom_range(0, 3) != 0) begin
        p.msg_type = msg_type_t'($urandom_range(0, 3));
        p.src_id   = 8'($urandom);
        p.payload  = $urandom;
        m = 4'($urandom);
        b0.in_pkt = p; b0.in_dir_mask = m; b0.in_valid = 1;
      end
      acc = b0.in_valid && b0.in_ready;
      if (acc) begin
        if (m == 4'd0) begin
          if (dmodel < 255) dmodel++;
        end else begin
          exp_push(p, m);
        end
        sent++;
      end
      tick();
      cyc++;
      if (acc) b0.in_valid = 0;
    end
    chk("rnd_sent", sent, 1000);
    b0.in_valid = 0;
    b0.tx_ready = 4'b1111;
    k = 0;
    while (busy0 && k < 100) begin tick(); k++; end
    tick();
    chk("rnd_drain", busy0, 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rnd_lost[%0d]", i), expq[i].size(), 0);
    chk("rnd_drop", drop0, dmodel);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/noc_tx_engine.md
Name: noc_tx_engine

Overview:
- Per-core NoC transmit engine that drives one core's four direction ports into the mesh interconnect.
- Accepts packets from the solver core (status, learned clauses) through a valid/ready interface and queues them in a FIFO.
- Fans each packet out to a per-packet set of direction ports, tracks completion independently per port, and pops the entry only when every selected port has handshaked.

Parameters:
- DEPTH, 4: FIFO entries (power of 2, ≥2).
- CORE_ID, 0: value stamped into src_id of every transmitted packet; width of the src_id field.
- NEIGHBOR_MASK, 4'b1111: bit per port that has a neighbour; bits at grid edges are cleared.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_pkt  input  noc_packet_t  packet from core
- in_dir_mask  input  4  requested destination ports, [3]=N [2]=S [1]=E [0]=W
- in_valid  input  1  in_pkt/in_dir_mask valid
- in_ready  output  1  engine can accept
- flush  input  1  synchronous discard of all queued and in-flight packets
- tx_pkt  output  noc_packet_t [3:0]  per-port packet to interconnect
- tx_valid  output  4  per-port valid
- tx_ready  input  4  per-port ready from interconnect
- fifo_count  output  $clog2(DEPTH)+1  occupied entries, including head
- drop_cnt  output  8  count of packets discarded for empty effective mask
- busy  output  1  fifo_count != 0

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: FIFO empty, pending=0, drop_cnt=0.
  - tx_valid=0; tx_pkt all fields 0 (msg_type=MSG_STATUS); in_ready=1; busy=0; fifo_count=0.
  - Assertion mid-transfer clears everything immediately; no partial completion is retained.
- Accept condition: in_valid & in_ready.
  - in_ready = (fifo_count < DEPTH) & ~flush. It does not depend on same-cycle pops.
- Effective mask: emask = in_dir_mask & NEIGHBOR_MASK.
  - If emask==0, the packet is accepted but not written; drop_cnt increments, saturating at 255.
  - Otherwise the entry stored is {in_pkt with src_id=CORE_ID, emask}. All other fields pass unchanged.
- Head and pending register:
  - pending[3:0] holds the outstanding ports of the FIFO head.
  - It loads from the head's emask whenever a new entry becomes head: a push into an empty FIFO, or a pop with a following entry present.
- Per-port outputs:
  - tx_valid[i] = head_valid & pending[i]. This is a registered-state function only; there is no combinational path from tx_ready or in_valid.
  - tx_pkt[i] = head packet when tx_valid[i], else zero.
- Port handshake: tx_valid[i] & tx_ready[i] clears pending[i] at the edge.
  - Once asserted, valid stays high and tx_pkt stays stable until that port handshakes.
  - Ports complete independently, in any order and on any cycle.
- Pop: when all remaining pending bits handshake in the current cycle, the head pops at the edge.
  - The next entry's pending loads on that same edge, so back-to-back packets have no bubble.
- Latency: a packet accepted at edge N into an empty FIFO shows tx_valid at cycle N+1.
- Simultaneous push and pop are allowed; fifo_count is unchanged in that cycle.
  - When full, in_ready=0 even if a pop occurs that cycle.
- Wrap-around: read and write pointers wrap modulo DEPTH.
  - fifo_count distinguishes full from empty.
- flush: at the next edge, FIFO and pending are cleared and tx_valid drops.
  - Flush has priority over push and pop.
  - drop_cnt is not affected.
  - Handshakes on the flush cycle are discarded.

Test Plan:
- Unicast: push msg_type=MSG_STATUS, payload=0x1234, mask=4'b0010, tx_ready=4'b1111.
  - Expect tx_valid=4'b0010 exactly one cycle after accept.
  - Expect tx_pkt[1].src_id=CORE_ID, payload=0x1234.
  - FIFO is empty the next cycle.
- Broadcast with staggered ready: mask=4'b1111, each tx_ready[i] asserted on a different cycle (W, E, S, N).
  - Expect each tx_valid bit to drop after its own handshake.
  - Expect the pop only after N's handshake.
  - Expect the next packet to appear the following cycle with no bubble.
- Edge core: NEIGHBOR_MASK=4'b0101, push mask=4'b1010.
  - Expect nothing transmitted, drop_cnt=1, fifo_count=0.
  - Then 300 such pushes: expect drop_cnt saturates at 255.
- Full/backpressure: DEPTH=4, tx_ready=0, push 5 packets.
  - Expect in_ready=0 after the 4th push and fifo_count=4.
  - Release tx_ready: expect 4 packets out in order, in_ready=1 again, and the 5th packet accepted.
- Flush and reset mid-broadcast: with mask=4'b1111 and 2 ports already done, assert flush.
  - Expect tx_valid=0 next cycle and fifo_count=0.
  - Repeat with rst_n=0 asserted between edges: expect tx_valid=0 immediately and all counters 0.
- Wrap stress: random masks and random tx_ready for 1000 packets.
  - Scoreboard checks per-port delivery order, no duplicates, no losses, and that tx_pkt is stable while tx_valid is high without ready.
